// File: rtl/aes_key_sched_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : aes_key_sched_iter
// Purpose  : Iterative AES-128 key schedule, one round key per accepted beat.
// Revision : 1.0
// ============================================================================
module aes_key_sched_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [0:127] key,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [0:127] rk,
  output logic [3:0]   rk_round,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  // Forward S-box, entry 0 in the leftmost byte.
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_t;
  state_t r_state;

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [7:0]   w_rc;
  logic [0:31]  w_rot;
  logic [0:31]  w_t;
  logic [0:31]  w_n0;
  logic [0:31]  w_n1;
  logic [0:31]  w_n2;
  logic [0:31]  w_n3;
  logic [0:127] w_next_key;

  assign w_rc = rcon(rk_round + 4'd1);

  always_comb begin
    w_rot      = {rk[104:127], rk[96:103]};
    w_t        = {sub_byte(w_rot[0:7]),   sub_byte(w_rot[8:15]),
                  sub_byte(w_rot[16:23]), sub_byte(w_rot[24:31])} ^ {w_rc, 24'h000000};
    w_n0       = rk[0:31]   ^ w_t;
    w_n1       = rk[32:63]  ^ w_n0;
    w_n2       = rk[64:95]  ^ w_n1;
    w_n3       = rk[96:127] ^ w_n2;
    w_next_key = {w_n0, w_n1, w_n2, w_n3};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rk       <= '0;
      rk_round <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            rk       <= key;
            rk_round <= 4'd0;
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            r_state  <= EMIT;
          end
        end
        EMIT: begin
          if (rk_ready) begin
            if (rk_round == LAST_ROUND) begin
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              r_state  <= IDLE;
            end else begin
              rk       <= w_next_key;
              rk_round <= rk_round + 4'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_sched_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_aes_key_sched_iter
// Purpose  : Scoreboard bench for the iterative AES-128 key scheduler.
// Revision : 1.0
// ============================================================================
module tb_aes_key_sched_iter;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] key;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk;
  logic [3:0]   rk_round;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  aes_key_sched_iter #(.NR(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .key      (key),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk       (rk),
    .rk_round (rk_round),
    .busy     (busy),
    .done     (done)
  );

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  typedef struct packed {
    logic [3:0]   round;
    logic [127:0] rkey;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           passes = 0;
  int           done_exp = 0;
  logic [7:0]   sbox_m[256];
  logic [127:0] model_rks[11];
  logic [127:0] got_rk[11];

  task automatic check_w(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  task automatic check_i(input string name, input int act, input int req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0d required %0d", name, act, req);
  endtask

  // Reference S-box from GF(2^8) inversion plus the affine map.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] v = x[7:0];
      logic [7:0] inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, v);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [7:0]  rc = 8'h01;
    logic [31:0] w3, t, n0, n1, n2, n3;
    model_rks[0] = k;
    for (int i = 1; i <= 10; i++) begin
      w3 = model_rks[i-1][31:0];
      t  = {sbox_m[w3[23:16]], sbox_m[w3[15:8]], sbox_m[w3[7:0]], sbox_m[w3[31:24]]} ^ {rc, 24'h0};
      n0 = model_rks[i-1][127:96] ^ t;
      n1 = model_rks[i-1][95:64]  ^ n0;
      n2 = model_rks[i-1][63:32]  ^ n1;
      n3 = w3 ^ n2;
      model_rks[i] = {n0, n1, n2, n3};
      rc = xt(rc);
    end
  endtask

  // Monitor: samples on the falling edge, half a cycle from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      done_exp = 0;
    end else begin
      check_i("done", int'(done), done_exp);
      done_exp = 0;
      if (rk_valid) begin
        if (exp_q.size() == 0) begin
          check_i("rk_valid_unexpected", int'(rk_valid), 0);
        end else begin
          check_i("rk_round", int'(rk_round), int'(exp_q[0].round));
          check_w("rk", rk, exp_q[0].rkey);
          check_i("busy_emit", int'(busy), 1);
          if (rk_ready) begin
            if (rk_round <= 4'd10) got_rk[rk_round] = rk;
            if (exp_q[0].round == 4'd10) done_exp = 1;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        check_i("busy_idle", int'(busy), 0);
      end
    end
  end

  task automatic begin_sched(input logic [127:0] k);
    exp_t e;
    model_expand(k);
    for (int r = 0; r < 11; r++) begin
      e.round = r[3:0];
      e.rkey  = model_rks[r];
      exp_q.push_back(e);
    end
    key   = k;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    key   = {$urandom, $urandom, $urandom, $urandom};
    check_i("start_valid", int'(rk_valid), 1);
    check_i("start_round", int'(rk_round), 0);
  endtask

  task automatic wait_done(input int pct, output int cyc);
    cyc = 0;
    while (1) begin
      rk_ready = ($urandom_range(99) < pct);
      @(posedge clk);
      #1;
      cyc++;
      if (done) break;
      if (cyc >= 300) begin
        check_i("done_timeout", int'(done), 1);
        break;
      end
    end
  endtask

  task automatic wait_round(input logic [3:0] r);
    for (int i = 0; i < 40; i++) begin
      if (rk_round == r) break;
      @(posedge clk);
      #1;
    end
    check_i("reach_round", int'(rk_round), int'(r));
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    start = 1'b0;
    rk_ready = 1'b0;
    key = '0;
    build_sbox();
    repeat (2) @(posedge clk);
    #1;
    check_i("rst_valid", int'(rk_valid), 0);
    check_i("rst_busy", int'(busy), 0);
    check_i("rst_done", int'(done), 0);
    check_w("rst_rk", rk, 128'h0);
    check_i("rst_round", int'(rk_round), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // FIPS-197 key, no stalls, exact latency
    begin_sched(FIPS_KEY);
    wait_done(100, cyc);
    check_i("fips_done_cycle", cyc, 11);
    check_i("fips_done_busy", int'(busy), 0);
    check_i("fips_done_valid", int'(rk_valid), 0);
    check_w("fips_r0", got_rk[0], FIPS_KEY);
    check_w("fips_r1", got_rk[1], FIPS_R1);
    check_w("fips_r10", got_rk[10], FIPS_R10);

    // All-zero key, started in the done cycle
    begin_sched(128'h0);
    wait_done(100, cyc);
    check_i("zero_done_cycle", cyc, 11);
    check_w("zero_r1", got_rk[1], ZERO_R1);
    check_w("zero_r10", got_rk[10], ZERO_R10);

    // Random stalls on the FIPS key
    begin_sched(FIPS_KEY);
    wait_done(50, cyc);
    check_w("stall_r1", got_rk[1], FIPS_R1);
    check_w("stall_r10", got_rk[10], FIPS_R10);

    // start with another key mid-schedule is ignored
    begin_sched(FIPS_KEY);
    rk_ready = 1'b1;
    wait_round(4'd4);
    key   = 128'h000102030405060708090a0b0c0d0e0f;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(100, cyc);
    check_w("ignore_r10", got_rk[10], FIPS_R10);
    begin_sched(128'h000102030405060708090a0b0c0d0e0f);
    wait_done(100, cyc);
    check_i("b2b_done_cycle", cyc, 11);

    // Asynchronous reset during round 6
    begin_sched(FIPS_KEY);
    rk_ready = 1'b1;
    wait_round(4'd6);
    #1;
    reset = 1'b1;
    #1;
    check_i("abort_valid", int'(rk_valid), 0);
    check_i("abort_busy", int'(busy), 0);
    check_i("abort_done", int'(done), 0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    begin_sched(FIPS_KEY);
    wait_done(100, cyc);
    check_i("post_rst_done_cycle", cyc, 11);
    check_w("post_rst_r10", got_rk[10], FIPS_R10);

    // Random keys, random stalls, mostly back-to-back
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(3) == 0) begin
        @(posedge clk);
        #1;
      end
      begin_sched({$urandom, $urandom, $urandom, $urandom});
      wait_done(50, cyc);
    end

    @(posedge clk);
    #1;
    check_i("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
